// File: rtl/kernel_cpu_cpu_nios2_oci_dct_packer.sv
// -----------------------------------------------------------------------------
// kernel_cpu_cpu_nios2_oci_dct_packer
//
// Packs 2-bit debug-control trace (DCT) atoms into 30-bit words of up to 15
// atoms each. Completed words go to the trace FIFO over valid/ready.
//
// Ports:
//   clk, reset        : CPU clock, synchronous active-high reset
//   trace_en          : capture enable; atoms are ignored while low
//   atom_valid, atom  : incoming trace atom (no backpressure)
//   flush             : single-cycle request to emit the partial word
//   out_valid/ready   : output handshake towards the trace FIFO
//   out_data          : packed atoms, slot i in bits [2i+1:2i]
//   out_count         : number of valid atoms in out_data (1..15)
//   dct_buffer/count  : live accumulator, exported for simulation monitoring
//   overflow          : sticky flag, an atom was dropped
//   overflow_clr      : clears overflow (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module kernel_cpu_cpu_nios2_oci_dct_packer #(
    parameter int ATOM_W = 2,
    parameter int SLOTS  = 15,
    parameter int CNT_W  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      trace_en,
    input  logic                      atom_valid,
    input  logic [ATOM_W-1:0]         atom,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ATOM_W*SLOTS-1:0]   out_data,
    output logic [CNT_W-1:0]          out_count,
    output logic [ATOM_W*SLOTS-1:0]   dct_buffer,
    output logic [CNT_W-1:0]          dct_count,
    output logic                      overflow,
    input  logic                      overflow_clr
);

    localparam int                 WORD_W = ATOM_W * SLOTS;
    localparam logic [CNT_W-1:0]   FULL   = CNT_W'(SLOTS);

    logic [WORD_W-1:0] dct_buffer_q, dct_buffer_d;
    logic [CNT_W-1:0]  dct_count_q,  dct_count_d;
    logic              out_valid_q,  out_valid_d;
    logic [WORD_W-1:0] out_data_q,   out_data_d;
    logic [CNT_W-1:0]  out_count_q,  out_count_d;
    logic              overflow_q,   overflow_d;
    logic              flush_pend_q, flush_pend_d;

    logic              accept_s;
    logic              full_s;
    logic              drop_s;
    logic [WORD_W-1:0] m_buf_s;
    logic [CNT_W-1:0]  m_cnt_s;
    logic              emit_req_s;
    logic              slot_free_s;

    // Merge the incoming atom, decide whether a word is emitted, and compute next state.
    always_comb begin
        dct_buffer_d = dct_buffer_q;
        dct_count_d  = dct_count_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_count_d  = out_count_q;
        overflow_d   = overflow_q;
        flush_pend_d = flush_pend_q;

        accept_s = trace_en & atom_valid;
        full_s   = (dct_count_q == FULL);
        drop_s   = accept_s & full_s;

        m_buf_s = dct_buffer_q;
        m_cnt_s = dct_count_q;
        if (accept_s & ~full_s) begin
            // Slot index is the current count; it never wraps because a full
            // accumulator drops instead of merging.
            for (int i = 0; i < SLOTS; i++) begin
                if (dct_count_q == CNT_W'(i)) begin
                    m_buf_s[i*ATOM_W +: ATOM_W] = atom;
                end else begin
                    m_buf_s[i*ATOM_W +: ATOM_W] = dct_buffer_q[i*ATOM_W +: ATOM_W];
                end
            end
            m_cnt_s = dct_count_q + CNT_W'(1);
        end else begin
            m_buf_s = dct_buffer_q;
            m_cnt_s = dct_count_q;
        end

        // A flush against an empty accumulator is a no-op.
        emit_req_s  = (m_cnt_s == FULL) |
                      ((flush | flush_pend_q) & (m_cnt_s != {CNT_W{1'b0}}));
        slot_free_s = ~out_valid_q | out_ready;

        if (emit_req_s & slot_free_s) begin
            out_data_d   = m_buf_s;
            out_count_d  = m_cnt_s;
            out_valid_d  = 1'b1;
            dct_buffer_d = {WORD_W{1'b0}};
            dct_count_d  = {CNT_W{1'b0}};
            flush_pend_d = 1'b0;
        end else begin
            dct_buffer_d = m_buf_s;
            dct_count_d  = m_cnt_s;
            out_valid_d  = out_valid_q & ~out_ready;
            // Remember a flush that could not be served; retried every cycle.
            flush_pend_d = flush_pend_q | (flush & emit_req_s);
        end

        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // State registers with synchronous reset; a held or partial word is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            dct_buffer_q <= {WORD_W{1'b0}};
            dct_count_q  <= {CNT_W{1'b0}};
            out_valid_q  <= 1'b0;
            out_data_q   <= {WORD_W{1'b0}};
            out_count_q  <= {CNT_W{1'b0}};
            overflow_q   <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            dct_buffer_q <= dct_buffer_d;
            dct_count_q  <= dct_count_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_count_q  <= out_count_d;
            overflow_q   <= overflow_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign dct_buffer = dct_buffer_q;
    assign dct_count  = dct_count_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_count  = out_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_kernel_cpu_cpu_nios2_oci_dct_packer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for kernel_cpu_cpu_nios2_oci_dct_packer. A queue-based
// reference model tracks the accumulator as a list of atoms and the output
// register as a single held word; every cycle all outputs are compared.
// -----------------------------------------------------------------------------
module tb_kernel_cpu_cpu_nios2_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trace_en = 1'b0;
    logic        atom_valid = 1'b0;
    logic [1:0]  atom = 2'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [29:0] out_data;
    logic [3:0]  out_count;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;
    logic        overflow_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [1:0]  acc_q[$];
    bit          hold_v;
    logic [29:0] hold_d;
    int          hold_c;
    bit          fpend;
    bit          ovf;

    kernel_cpu_cpu_nios2_oci_dct_packer dut (
        .clk          (clk),
        .reset        (reset),
        .trace_en     (trace_en),
        .atom_valid   (atom_valid),
        .atom         (atom),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_count    (out_count),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] pack_atoms(input logic [1:0] q[$]);
        logic [29:0] r;
        r = 30'd0;
        foreach (q[i]) r = r | (30'(q[i]) << (2 * i));
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit take, drop, want, free;
        if (reset) begin
            acc_q.delete();
            hold_v = 1'b0; hold_d = 30'd0; hold_c = 0; fpend = 1'b0; ovf = 1'b0;
        end else begin
            take = trace_en && atom_valid;
            drop = take && (acc_q.size() == 15);
            if (take && !drop) acc_q.push_back(atom);
            want = (acc_q.size() == 15) || ((flush || fpend) && acc_q.size() > 0);
            free = !hold_v || out_ready;
            if (want && free) begin
                hold_d = pack_atoms(acc_q);
                hold_c = acc_q.size();
                hold_v = 1'b1;
                acc_q.delete();
                fpend = 1'b0;
            end else begin
                if (out_ready) hold_v = 1'b0;
                if (want) fpend = fpend || flush;
            end
            if (drop) ovf = 1'b1;
            else if (overflow_clr) ovf = 1'b0;
        end
    endtask

    task automatic cyc(input bit te, input bit av, input logic [1:0] a, input bit fl,
                       input bit rdy, input bit clr, input bit rst);
        trace_en = te; atom_valid = av; atom = a; flush = fl;
        out_ready = rdy; overflow_clr = clr; reset = rst;
        @(posedge clk);
        model_step();
        #1;
        check("out_valid",  32'(out_valid),  32'(hold_v));
        check("out_data",   32'(out_data),   32'(hold_d));
        check("out_count",  32'(out_count),  32'(hold_c));
        check("dct_buffer", 32'(dct_buffer), 32'(pack_atoms(acc_q)));
        check("dct_count",  32'(dct_count),  32'(acc_q.size()));
        check("overflow",   32'(overflow),   32'(ovf));
    endtask

    initial begin
        // Reset
        cyc(0, 0, 2'd0, 0, 0, 0, 1);
        cyc(0, 0, 2'd0, 0, 0, 0, 1);

        // 1: 15 atoms 0,1,2,3,... with ready high
        for (int i = 0; i < 15; i++) cyc(1, 1, 2'(i % 4), 0, 1, 0, 0);
        check("t1_word", 32'(out_data), 32'h24E4E4E4);
        check("t1_cnt", 32'(out_count), 32'd15);
        cyc(1, 0, 2'd0, 0, 1, 0, 0);

        // 2: atoms 3,0,2 then flush; then flush with empty accumulator
        cyc(1, 1, 2'd3, 0, 1, 0, 0);
        cyc(1, 1, 2'd0, 0, 1, 0, 0);
        cyc(1, 1, 2'd2, 0, 1, 0, 0);
        cyc(1, 0, 2'd0, 1, 1, 0, 0);
        check("t2_word", 32'(out_data), 32'h23);
        check("t2_cnt", 32'(out_count), 32'd3);
        cyc(1, 0, 2'd0, 0, 1, 0, 0);
        cyc(1, 0, 2'd0, 1, 1, 0, 0);
        check("t2_empty_flush", 32'(out_valid), 32'd0);

        // 3: ready low, fill a word, then a second full word, then a drop
        for (int i = 0; i < 15; i++) cyc(1, 1, 2'($urandom_range(3)), 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) cyc(1, 1, 2'($urandom_range(3)), 0, 0, 0, 0);
        cyc(1, 1, 2'd1, 0, 0, 0, 0);
        check("t3_ovf", 32'(overflow), 32'd1);
        // drop together with clear: overflow stays set
        cyc(1, 1, 2'd2, 0, 0, 1, 0);
        cyc(1, 0, 2'd0, 0, 1, 0, 0);
        cyc(1, 0, 2'd0, 0, 1, 0, 0);
        cyc(1, 0, 2'd0, 0, 1, 1, 0);
        check("t3_ovf_clr", 32'(overflow), 32'd0);

        // 4: flush while busy with 4 atoms, then one more atom before release
        for (int i = 0; i < 15; i++) cyc(1, 1, 2'($urandom_range(3)), 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 2'($urandom_range(3)), 0, 0, 0, 0);
        cyc(1, 0, 2'd0, 1, 0, 0, 0);
        cyc(1, 1, 2'd3, 0, 0, 0, 0);
        cyc(1, 0, 2'd0, 0, 1, 0, 0);
        check("t4_cnt", 32'(out_count), 32'd5);
        cyc(1, 0, 2'd0, 0, 1, 0, 0);

        // 5: atom and flush together at count 14
        for (int i = 0; i < 14; i++) cyc(1, 1, 2'($urandom_range(3)), 0, 1, 0, 0);
        cyc(1, 1, 2'd2, 1, 1, 0, 0);
        check("t5_cnt", 32'(out_count), 32'd15);
        cyc(1, 0, 2'd0, 0, 1, 0, 0);
        check("t5_no_second", 32'(out_valid), 32'd0);

        // 6: reset mid-operation with a held word and 7 atoms
        for (int i = 0; i < 15; i++) cyc(1, 1, 2'($urandom_range(3)), 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(1, 1, 2'($urandom_range(3)), 0, 0, 0, 0);
        cyc(1, 1, 2'd1, 0, 0, 0, 1);
        check("t6_rst_valid", 32'(out_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(7) != 0), ($urandom_range(3) != 0), 2'($urandom_range(3)),
                ($urandom_range(9) == 0), ($urandom_range(3) != 0),
                ($urandom_range(15) == 0), ($urandom_range(199) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
